calc_cmd_arbiter: RTL and testbench

- Shares the calculator's single 4-bit cmd input between two requesters: A is the keypad, B is the macro/script source.
- Presents each accepted command on cmd_out as a stable pulse of HOLD_CYC cycles, then a NOP gap of GAP_CYC cycles.
- Waits while the calculator reports busy.
- Locks the calculator to one requester from that requester's first command until the expression completes, so operands from the two sources never interleave.

---
 rtl/calc_pkg.sv | 31 +++
 rtl/calc_pulse_timer.sv | 26 ++
 rtl/calc_cmd_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_calc_cmd_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared command, status and FSM state encodings for the calculator command arbiter.
package calc_pkg;

  typedef enum logic [3:0] {
    DIG0 = 4'h0, DIG1 = 4'h1, DIG2 = 4'h2, DIG3 = 4'h3, DIG4 = 4'h4,
    DIG5 = 4'h5, DIG6 = 4'h6, DIG7 = 4'h7, DIG8 = 4'h8, DIG9 = 4'h9,
    ADD  = 4'hA, SUB  = 4'hB, MUL  = 4'hC, CLR  = 4'hD, EQ   = 4'hE,
    NOP  = 4'hF
  } cmd_t;

  typedef enum logic [1:0] {
    ST_READY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_ERR   = 2'b10,
    ST_OVF   = 2'b11
  } status_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HOLD     = 3'd1,
    S_GAP      = 3'd2,
    S_WAIT_RDY = 3'd3,
    S_FLUSH    = 3'd4
  } arb_state_t;

  // EQ and CLR terminate the expression and release the lock.
  function automatic logic ends_expr(input cmd_t c);
    return (c == EQ) || (c == CLR);
  endfunction

endpackage

// File: rtl/calc_pulse_timer.sv
// Loadable down-counter that stops at zero; done_o is high while the count is zero.
module calc_pulse_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/calc_cmd_arbiter.sv
// Arbitrates keypad (A) and macro (B) commands onto the calculator cmd bus,
// pulsing each for HOLD_CYC cycles with a GAP_CYC NOP gap and per-expression locking.
module calc_cmd_arbiter
  import calc_pkg::*;
#(
  parameter int unsigned HOLD_CYC     = 10,
  parameter int unsigned GAP_CYC      = 10,
  parameter int unsigned LOCK_TIMEOUT = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_a,
  input  logic [3:0] cmd_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic [3:0] cmd_b,
  output logic       ack_b,
  input  logic [1:0] calc_status,
  output logic [3:0] cmd_out,
  output logic [1:0] grant,
  output logic       locked,
  output logic [2:0] state
);

  localparam int unsigned TMAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned IW   = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYC - 1);

  arb_state_t    state_q;
  cmd_t          cmd_out_q;
  logic          ack_a_q, ack_b_q;
  logic [1:0]    grant_q;
  logic          locked_q;
  logic          ptr_q;        // 0: A has priority on contention, 1: B
  logic          release_q;
  logic          flush_gap_q;
  logic [IW-1:0] idle_cnt_q;

  status_t       status;
  logic          acc_a, acc_b, acc, owner_req, timeout_hit;
  cmd_t          acc_cmd;
  logic          tmr_load, tmr_done;
  logic [TW-1:0] tmr_val;

  assign status = status_t'(calc_status);

  always_comb begin
    acc_a     = 1'b0;
    acc_b     = 1'b0;
    owner_req = locked_q && (grant_q[0] ? req_a : req_b);
    if (state_q == S_IDLE && status != ST_BUSY) begin
      if (locked_q) begin
        acc_a = grant_q[0] && req_a;
        acc_b = grant_q[1] && req_b;
      end else if (req_a && req_b) begin
        acc_a = !ptr_q;
        acc_b = ptr_q;
      end else begin
        acc_a = req_a;
        acc_b = req_b;
      end
    end
    acc         = acc_a || acc_b;
    acc_cmd     = acc_b ? cmd_t'(cmd_b) : cmd_t'(cmd_a);
    timeout_hit = (state_q == S_IDLE) && locked_q && !owner_req &&
                  (idle_cnt_q == IW'(LOCK_TIMEOUT - 1));
  end

  // One timer serves HOLD, GAP and both FLUSH phases; it is reloaded on each phase entry.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      S_IDLE: begin
        if ((acc && acc_cmd != NOP) || timeout_hit) begin
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      S_HOLD: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      S_WAIT_RDY: begin
        if (status == ST_ERR || status == ST_OVF) begin
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      S_FLUSH: begin
        if (tmr_done && !flush_gap_q) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      default: ;
    endcase
  end

  calc_pulse_timer #(.WIDTH(TW)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cmd_out_q   <= NOP;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      grant_q     <= 2'b00;
      locked_q    <= 1'b0;
      ptr_q       <= 1'b0;
      release_q   <= 1'b0;
      flush_gap_q <= 1'b0;
      idle_cnt_q  <= '0;
    end else begin
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A stalled non-owner is served first once the lock drops.
          if (locked_q && (grant_q[0] ? req_b : req_a)) ptr_q <= grant_q[0];
          if (acc) begin
            ack_a_q    <= acc_a;
            ack_b_q    <= acc_b;
            idle_cnt_q <= '0;
            if (!locked_q && req_a && req_b) ptr_q <= !ptr_q;
            if (acc_cmd != NOP) begin
              cmd_out_q <= acc_cmd;
              state_q   <= S_HOLD;
              release_q <= ends_expr(acc_cmd);
              if (!locked_q) begin
                locked_q <= 1'b1;
                grant_q  <= acc_b ? 2'b10 : 2'b01;
              end
            end
          end else if (locked_q && !owner_req) begin
            if (timeout_hit) begin
              state_q     <= S_FLUSH;
              cmd_out_q   <= CLR;
              flush_gap_q <= 1'b0;
              idle_cnt_q  <= '0;
            end else begin
              idle_cnt_q <= idle_cnt_q + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (tmr_done) begin
            cmd_out_q <= NOP;
            state_q   <= S_GAP;
          end
        end
        S_GAP: begin
          if (tmr_done) begin
            state_q <= S_WAIT_RDY;
            if (release_q) begin
              locked_q  <= 1'b0;
              grant_q   <= 2'b00;
              release_q <= 1'b0;
            end
          end
        end
        S_WAIT_RDY: begin
          case (status)
            ST_READY: state_q <= S_IDLE;
            ST_BUSY:  state_q <= S_WAIT_RDY;
            default: begin
              state_q     <= S_FLUSH;
              cmd_out_q   <= CLR;
              flush_gap_q <= 1'b0;
            end
          endcase
        end
        S_FLUSH: begin
          if (tmr_done) begin
            if (!flush_gap_q) begin
              cmd_out_q   <= NOP;
              flush_gap_q <= 1'b1;
            end else begin
              state_q     <= S_IDLE;
              locked_q    <= 1'b0;
              grant_q     <= 2'b00;
              release_q   <= 1'b0;
              flush_gap_q <= 1'b0;
              idle_cnt_q  <= '0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_out = cmd_out_q;
  assign ack_a   = ack_a_q;
  assign ack_b   = ack_b_q;
  assign grant   = grant_q;
  assign locked  = locked_q;
  assign state   = state_q;

endmodule

// File: tb/tb_calc_cmd_arbiter.sv
// Directed bench for calc_cmd_arbiter: lock/arbitration, pulse timing, busy, flush, timeout, reset.
module tb_calc_cmd_arbiter;

  localparam int unsigned HOLD = 10;
  localparam int unsigned GAP  = 10;
  localparam int unsigned LT   = 1000;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [3:0] cmd_a = 4'hF, cmd_b = 4'hF;
  logic [1:0] calc_status = 2'b00;
  logic       ack_a, ack_b, locked;
  logic [3:0] cmd_out;
  logic [1:0] grant;
  logic [2:0] state;

  int n_assert = 0;
  int n_fail   = 0;
  int ack_a_cnt = 0;
  int ack_b_cnt = 0;
  logic       lk_at_ack;
  logic [1:0] gr_at_ack;

  calc_cmd_arbiter #(.HOLD_CYC(HOLD), .GAP_CYC(GAP), .LOCK_TIMEOUT(LT)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .cmd_a(cmd_a), .ack_a(ack_a),
    .req_b(req_b), .cmd_b(cmd_b), .ack_b(ack_b),
    .calc_status(calc_status), .cmd_out(cmd_out),
    .grant(grant), .locked(locked), .state(state)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ack_a === 1'b1) ack_a_cnt++;
    if (ack_b === 1'b1) ack_b_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_ack(input bit side_b, input string tag);
    int i = 0;
    while (((side_b ? ack_b : ack_a) !== 1'b1) && i < 300) begin
      tick();
      i++;
    end
    chk({tag, "_ack"}, 32'(side_b ? ack_b : ack_a), 32'd1);
    if (side_b) req_b = 1'b0;
    else        req_a = 1'b0;
    lk_at_ack = locked;
    gr_at_ack = grant;
  endtask

  // Called on the ack cycle; returns on the first WAIT_RDY cycle.
  task automatic finish_cmd(input logic [3:0] c, input string tag);
    int h = 0, g = 0, bad = 0;
    while (state === 3'd1 && h < 50) begin
      if (cmd_out !== c) bad++;
      h++;
      tick();
    end
    while (state === 3'd2 && g < 50) begin
      if (cmd_out !== 4'hF) bad++;
      g++;
      tick();
    end
    chk({tag, "_hold"}, 32'(h), 32'(HOLD));
    chk({tag, "_gap"}, 32'(g), 32'(GAP));
    chk({tag, "_bus"}, 32'(bad), 32'd0);
    chk({tag, "_wait"}, 32'(state), 32'd3);
  endtask

  task automatic run_cmd(input bit side_b, input logic [3:0] c, input string tag);
    if (side_b) begin req_b = 1'b1; cmd_b = c; end
    else        begin req_a = 1'b1; cmd_a = c; end
    wait_ack(side_b, tag);
    chk({tag, "_out"}, 32'(cmd_out), 32'(c));
    finish_cmd(c, tag);
  endtask

  // Called on the first FLUSH cycle; returns on the following IDLE cycle.
  task automatic flush_check(input string tag);
    int c = 0, n = 0;
    while (state === 3'd4 && cmd_out === 4'hD && c < 100) begin c++; tick(); end
    while (state === 3'd4 && cmd_out === 4'hF && n < 100) begin n++; tick(); end
    chk({tag, "_clr"}, 32'(c), 32'(HOLD));
    chk({tag, "_nop"}, 32'(n), 32'(GAP));
    chk({tag, "_idle"}, 32'(state), 32'd0);
    chk({tag, "_unlk"}, 32'(locked), 32'd0);
    chk({tag, "_gnt"}, 32'(grant), 32'd0);
  endtask

  initial begin
    int bad;
    int a_before;
    int i;

    // Reset
    tick(2);
    chk("rst_cmd", 32'(cmd_out), 32'hF);
    chk("rst_acka", 32'(ack_a), 32'd0);
    chk("rst_ackb", 32'(ack_b), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_lock", 32'(locked), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    reset = 1'b1;
    tick();

    // 1: A issues 1 2 + 3 =
    run_cmd(1'b0, 4'h1, "t1_d1");
    chk("t1_lock_on", 32'(lk_at_ack), 32'd1);
    chk("t1_grant_a", 32'(gr_at_ack), 32'b01);
    run_cmd(1'b0, 4'h2, "t1_d2");
    run_cmd(1'b0, 4'hA, "t1_add");
    run_cmd(1'b0, 4'h3, "t1_d3");
    chk("t1_still_lock", 32'(locked), 32'd1);
    run_cmd(1'b0, 4'hE, "t1_eq");
    chk("t1_unlock", 32'(locked), 32'd0);
    chk("t1_ungrant", 32'(grant), 32'd0);
    chk("t1_acks", 32'(ack_a_cnt), 32'd5);

    // 2/3: contention, A wins; B stalls through A's expression, then goes first
    tick();
    req_a = 1'b1; cmd_a = 4'h5;
    req_b = 1'b1; cmd_b = 4'h7;
    wait_ack(1'b0, "t2_a5");
    chk("t2_ackb_lo", 32'(ack_b), 32'd0);
    chk("t2_grant_a", 32'(grant), 32'b01);
    chk("t2_out5", 32'(cmd_out), 32'h5);
    finish_cmd(4'h5, "t2_a5");
    run_cmd(1'b0, 4'hA, "t2_add");
    run_cmd(1'b0, 4'h2, "t2_d2");
    run_cmd(1'b0, 4'hE, "t2_eq");
    chk("t3_b_stalled", 32'(ack_b_cnt), 32'd0);
    chk("t2_unlock", 32'(locked), 32'd0);
    req_a = 1'b1; cmd_a = 4'h3;
    tick();
    chk("t3_idle", 32'(state), 32'd0);
    chk("t3_ackb_idle", 32'(ack_b), 32'd0);
    tick();
    chk("t3_ackb", 32'(ack_b), 32'd1);
    chk("t3_acka_lo", 32'(ack_a), 32'd0);
    chk("t3_out7", 32'(cmd_out), 32'h7);
    chk("t3_grant_b", 32'(grant), 32'b10);
    req_b = 1'b0;
    a_before = ack_a_cnt;
    finish_cmd(4'h7, "t3_b7");
    run_cmd(1'b1, 4'hE, "t3_beq");
    chk("t3_a_stalled", 32'(ack_a_cnt), 32'(a_before));
    wait_ack(1'b0, "t3_a3");
    chk("t3_grant_a", 32'(grant), 32'b01);
    chk("t3_out3", 32'(cmd_out), 32'h3);
    finish_cmd(4'h3, "t3_a3");
    run_cmd(1'b0, 4'hE, "t3_aeq");

    // 4: busy for 50 cycles in WAIT_RDY
    run_cmd(1'b0, 4'h4, "t4_d4");
    calc_status = 2'b01;
    req_a = 1'b1; cmd_a = 4'hE;
    bad = 0;
    repeat (50) begin
      tick();
      if (state !== 3'd3 || cmd_out !== 4'hF || ack_a !== 1'b0) bad++;
    end
    chk("t4_busy_hold", 32'(bad), 32'd0);
    calc_status = 2'b00;
    tick();
    chk("t4_idle", 32'(state), 32'd0);
    chk("t4_noack", 32'(ack_a), 32'd0);
    tick();
    chk("t4_ack", 32'(ack_a), 32'd1);
    chk("t4_out", 32'(cmd_out), 32'hE);
    req_a = 1'b0;
    finish_cmd(4'hE, "t4_eq");
    tick();
    // Busy in IDLE blocks acceptance; an unlocked NOP is acked but not forwarded
    calc_status = 2'b01;
    req_a = 1'b1; cmd_a = 4'hF;
    bad = 0;
    repeat (5) begin
      tick();
      if (ack_a !== 1'b0 || state !== 3'd0) bad++;
    end
    chk("t4_idle_busy", 32'(bad), 32'd0);
    calc_status = 2'b00;
    tick();
    chk("t4_nop_ack", 32'(ack_a), 32'd1);
    chk("t4_nop_state", 32'(state), 32'd0);
    chk("t4_nop_out", 32'(cmd_out), 32'hF);
    chk("t4_nop_lock", 32'(locked), 32'd0);
    req_a = 1'b0;
    tick();
    chk("t4_nop_pulse", 32'(ack_a), 32'd0);

    // 5: error in WAIT_RDY forces FLUSH
    run_cmd(1'b0, 4'h6, "t5_d6");
    calc_status = 2'b10;
    tick();
    chk("t5_flush", 32'(state), 32'd4);
    flush_check("t5");
    calc_status = 2'b00;

    // 6: owner idle past LOCK_TIMEOUT
    run_cmd(1'b0, 4'h9, "t6_d9");
    tick();
    i = 0;
    while (state === 3'd0 && i < 3000) begin i++; tick(); end
    chk("t6_idle_cycles", 32'(i), 32'(LT));
    chk("t6_flush", 32'(state), 32'd4);
    chk("t6_lock_in_flush", 32'(locked), 32'd1);
    flush_check("t6");

    // 6b: reset during HOLD
    req_a = 1'b1; cmd_a = 4'h2;
    wait_ack(1'b0, "t6b");
    tick(3);
    chk("t6b_hold", 32'(state), 32'd1);
    reset = 1'b0;
    tick();
    chk("t6b_cmd", 32'(cmd_out), 32'hF);
    chk("t6b_state", 32'(state), 32'd0);
    chk("t6b_lock", 32'(locked), 32'd0);
    chk("t6b_grant", 32'(grant), 32'd0);
    reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
